// File: rtl/wb_trace_buffer.sv
// Writeback/branch trace buffer: a capture window of CYCLE_LIMIT cycles pushes qualified events into a FIFO.
// Optional macro TRACE_BRANCH_EN: taken branches also qualify as events and set rd_kind[1].
module wb_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int CYCLE_LIMIT = 1500
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       arm,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       branch_taken,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [1:0]                 rd_kind,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [CNT_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       busy,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 2 + ADDR_W + DATA_W + CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [ENT_W-1:0]   head_q, head_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic br_ev, in_cap, start, last, push, pop, full, push_ok, drop;
  logic [ENT_W-1:0] entry;

`ifdef TRACE_BRANCH_EN
  assign br_ev = branch_taken;
`else
  // Branch input is tied off; the AND keeps it formally read without adding logic.
  assign br_ev = 1'b0 & branch_taken;
`endif

  assign in_cap  = (state_q == S_CAPTURE);
  assign start   = !in_cap && arm;
  assign last    = in_cap && (cnt_q == CNT_W'(CYCLE_LIMIT - 1));
  assign push    = in_cap && (wb_en || br_ev);
  assign pop     = rd_valid && rd_ready;
  assign full    = (count_q == OCC_W'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign entry   = {br_ev, wb_en,
                    wb_en ? wb_addr : {ADDR_W{1'b0}},
                    wb_en ? wb_data : {DATA_W{1'b0}},
                    cnt_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    head_d  = head_q;
    if (start) begin
      state_d = S_CAPTURE;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (in_cap) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = S_DONE;
      end
      if (pop)     rptr_d = rptr_q + PTR_W'(1);
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + OCC_W'(1);
      else if (!push_ok && pop) count_d = count_q - OCC_W'(1);
      if (drop) ovf_d = 1'b1;
      // Head register tracks the next head; the freshly written entry is not in mem_q yet.
      if (count_d != '0)
        head_d = (push_ok && (rptr_d == wptr_q)) ? entry : mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= entry;
  end

  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == S_CAPTURE);
  assign done     = (state_q == S_DONE);
  assign rd_kind  = head_q[ENT_W-1 -: 2];
  assign rd_addr  = head_q[ADDR_W+DATA_W+CNT_W-1 -: ADDR_W];
  assign rd_data  = head_q[DATA_W+CNT_W-1 -: DATA_W];
  assign rd_cycle = head_q[CNT_W-1:0];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Randomized and directed bench for wb_trace_buffer against a queue-based reference model.
module tb_wb_trace_buffer;
  localparam int DATA_W = 32, ADDR_W = 4, DEPTH = 4, CNT_W = 16, LIMIT = 10;

  logic clk = 1'b0, reset_n = 1'b0;
  logic arm = 0, wb_en = 0, branch_taken = 0, rd_ready = 0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic rd_valid, overflow, busy, done;
  logic [1:0] rd_kind;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0] rd_cycle;
  logic [2:0] count;

  wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
                    .CYCLE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .branch_taken(branch_taken), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_cycle(rd_cycle), .count(count), .overflow(overflow), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] kind; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc; } ent_t;
  ent_t mq[$];
  ent_t m_head;
  bit   m_act, m_done, m_ovf;
  int   m_cnt;
  int   errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_act = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
    m_head = '{2'b0, '0, '0, 0};
  endtask

  task automatic model_edge();
    bit pop, ev;
    ent_t e;
    pop = (mq.size() != 0) && rd_ready;
`ifdef TRACE_BRANCH_EN
    ev = wb_en || branch_taken;
    e.kind = {branch_taken, wb_en};
`else
    ev = wb_en;
    e.kind = {1'b0, wb_en};
`endif
    e.addr = wb_en ? wb_addr : '0;
    e.data = wb_en ? wb_data : '0;
    e.cyc  = m_cnt;
    if (m_act) begin
      if (pop) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1;
      end
      if (m_cnt == LIMIT - 1) begin m_act = 0; m_done = 1; end
      m_cnt++;
    end else if (arm) begin
      m_act = 1; m_done = 0; m_cnt = 0; m_ovf = 0; mq.delete();
    end else if (pop) begin
      void'(mq.pop_front());
    end
    if (mq.size() != 0) m_head = mq[0];
  endtask

  task automatic compare_all();
    chk("rd_valid", 64'(rd_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("busy", 64'(busy), 64'(m_act));
    chk("done", 64'(done), 64'(m_done));
    chk("rd_kind", 64'(rd_kind), 64'(m_head.kind));
    chk("rd_addr", 64'(rd_addr), 64'(m_head.addr));
    chk("rd_data", 64'(rd_data), 64'(m_head.data));
    chk("rd_cycle", 64'(rd_cycle), 64'(m_head.cyc));
  endtask

  task automatic step(input logic a, input logic we, input logic [ADDR_W-1:0] ad,
                      input logic [DATA_W-1:0] d, input logic br, input logic rr);
    arm = a; wb_en = we; wb_addr = ad; wb_data = d; branch_taken = br; rd_ready = rr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_window_end();
    for (int i = 0; i < 2 * LIMIT && m_act; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    @(posedge clk); #1 reset_n = 1'b1;
    compare_all();

    // Basic capture with immediate consumer
    step(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 4'd5, 32'd7, 0, 1);
    chk("basic_valid", 64'(rd_valid), 64'd1);
    chk("basic_kind", 64'(rd_kind), 64'd1);
    chk("basic_addr", 64'(rd_addr), 64'd5);
    chk("basic_data", 64'(rd_data), 64'd7);
    chk("basic_cycle", 64'(rd_cycle), 64'd3);
    step(0, 0, 0, 0, 0, 1);
    chk("basic_drained", 64'(rd_valid), 64'd0);
    wait_window_end();

    // Overflow: six writebacks into a depth-4 FIFO with no consumer
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 4'(i + 1), 32'(100 + i), 0, 0);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(rd_data), 64'(100 + i));
      step(0, 0, 0, 0, 0, 1);
    end
    wait_window_end();

    // Full FIFO with simultaneous push and pop
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'(i), 32'(200 + i), 0, 0);
    step(0, 1, 4'd9, 32'd999, 0, 1);
    chk("pushpop_count", 64'(count), 64'd4);
    chk("pushpop_ovf", 64'(overflow), 64'd0);
    wait_window_end();

    // Window end: writebacks at counters 9 and 10, only 9 captured
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < LIMIT; c++) step(0, c == 9, 4'd3, 32'(c), 0, 0);
    chk("win_done", 64'(done), 64'd1);
    step(0, 1, 4'd3, 32'd10, 0, 0);
    chk("win_count", 64'(count), 64'd1);
    chk("win_cycle", 64'(rd_cycle), 64'd9);
    step(0, 0, 0, 0, 0, 1);
    chk("win_drain", 64'(count), 64'd0);

    // Branch qualification
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 4'd2, 32'hAB, 1, 0);
`ifdef TRACE_BRANCH_EN
    chk("br_count", 64'(count), 64'd2);
`else
    chk("br_count", 64'(count), 64'd1);
    chk("br_kind", 64'(rd_kind), 64'd1);
`endif

    // Async reset mid-capture with three entries queued
    step(0, 1, 4'd1, 32'd1, 0, 0);
    step(0, 1, 4'd2, 32'd2, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    model_reset();
    compare_all();
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 4'd4, 32'd4, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 32: writeback data width.
REQ-002 Parameter ADDR_W, default 4: register-address width.
REQ-003 Parameter DEPTH, default 16, power of two, minimum 2: trace FIFO entries.
REQ-004 Parameter CNT_W, default 16: cycle-counter width.
REQ-005 Parameter CYCLE_LIMIT, default 1500, range 1 to 2^CNT_W-1: capture-window length in cycles.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 arm  in  1  start or restart a capture window.
REQ-009 wb_en  in  1  register writeback occurs this cycle.
REQ-010 wb_addr  in  ADDR_W  destination register.
REQ-011 wb_data  in  DATA_W  written value.
REQ-012 branch_taken  in  1  branch resolved taken this cycle.
REQ-013 rd_ready  in  1  consumer accepts the head entry.
REQ-014 rd_valid  out  1  head entry is available.
REQ-015 rd_kind  out  2  bit0 = writeback, bit1 = branch.
REQ-016 rd_addr / rd_data / rd_cycle  out  ADDR_W / DATA_W / CNT_W  head entry fields.
REQ-017 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 overflow  out  1  sticky: at least one event was dropped.
REQ-019 busy / done  out  1 / 1  state is CAPTURE / state is DONE.

Function
REQ-020 FSM states SHALL be IDLE, CAPTURE and DONE.
REQ-021 Transitions:
- IDLE or DONE with arm=1 -> CAPTURE.
- CAPTURE -> DONE on the edge where cycle counter = CYCLE_LIMIT-1.
- arm in CAPTURE is ignored.
REQ-022 Entering CAPTURE SHALL clear the cycle counter, overflow and the FIFO on the same edge.
REQ-023 In CAPTURE the cycle counter SHALL increment by 1 per cycle; it holds its value in IDLE and DONE.
REQ-024 Event qualification: in CAPTURE, an event SHALL be pushed when wb_en=1 (or when branch_taken=1 under REQ-035).
REQ-025 Pushed entry contents: {kind, wb_addr, wb_data, current counter}. wb_addr and wb_data are zeroed when wb_en=0.
REQ-026 Full FIFO: a push with no simultaneous pop SHALL be dropped and SHALL set overflow.
REQ-027 Simultaneous push and pop while full: both accepted, count unchanged, no overflow.
REQ-028 Pop occurs when rd_valid & rd_ready, in any state; a pop in DONE drains the FIFO.
REQ-029 Push-to-rd_valid latency SHALL be 1 cycle; there is no same-cycle bypass.
REQ-030 When the FIFO is empty, rd_valid=0 and rd_* outputs hold their last values.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Events on the CAPTURE->DONE edge itself are still captured; events in IDLE or DONE are ignored.

Reset
REQ-033 reset_n=0 SHALL asynchronously force:
- state IDLE;
- counter 0, pointers 0, count 0;
- overflow 0, rd_valid 0, busy 0, done 0;
- rd_kind, rd_addr, rd_data, rd_cycle all 0.
REQ-034 Reset mid-capture SHALL discard all entries; capture restarts only on a new arm after reset release.

Configuration
REQ-035 Macro TRACE_BRANCH_EN defined: branch_taken=1 qualifies an event and sets rd_kind[1]; wb_en and branch_taken in the same cycle produce one entry with rd_kind=2'b11.
REQ-036 Macro TRACE_BRANCH_EN undefined: branch_taken is ignored and rd_kind[1] is constant 0.

Verification
REQ-037 Basic capture: reset, arm at cycle 0, wb_en at counter 3 with addr 5, data 7, rd_ready=1 -> one entry {kind 01, addr 5, data 7, cycle 3}, rd_valid high exactly one cycle later.
REQ-038 Overflow: DEPTH=4, rd_ready=0, 6 consecutive writebacks -> count=4, overflow=1, entries hold the first 4 writebacks in order.
REQ-039 Full with simultaneous push/pop: FIFO full, wb_en=1 and rd_ready=1 in the same cycle -> count stays 4, overflow stays 0.
REQ-040 Window end: CYCLE_LIMIT=10, arm -> done=1 after 10 cycles; wb_en at counters 9 and 10 -> only counter 9 is captured; rd_ready then drains the FIFO to count 0.
REQ-041 Async reset: reset_n dropped mid-capture with 3 entries queued -> immediately count=0, rd_valid=0, state IDLE.
REQ-042 TRACE_BRANCH_EN defined: wb_en and branch_taken at counter 2 -> one entry with kind 11 and cycle 2. TRACE_BRANCH_EN undefined: branch_taken alone -> no entry.
